// File: rtl/shift_reg_ctrl.sv
// rtl/shift_reg_ctrl.sv - universal shift register with self-timed serial burst engine
//
// Optional feature macro: SHREG_ROTATE_EN (rotate feedback on shifts when rot=1).
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   en      in   clock enable; holds q, state and counter when low
//   mode    in   [1:0] 00 hold, 01 shift left, 10 shift right, 11 parallel load
//   d       in   [WIDTH-1:0] parallel load data
//   sin_l   in   serial in entering the MSB on a right shift
//   sin_r   in   serial in entering the LSB on a left shift
//   start   in   burst request, honoured in IDLE only
//   dir     in   burst direction latched with start: 0 left/MSB first, 1 right/LSB first
//   rot     in   rotate select, effective only with SHREG_ROTATE_EN
//   q       out  [WIDTH-1:0] register contents
//   sout_l  out  q[WIDTH-1]
//   sout_r  out  q[0]
//   busy    out  high while a burst is in progress
//   done    out  one-cycle pulse after the last burst shift

module shift_reg_ctrl #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic             dir,
  input  logic             rot,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             dir_q, dir_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] shl_val, shr_val;
  logic             fill_r, fill_l;

`ifdef SHREG_ROTATE_EN
  // With rot set, the outgoing bit wraps around instead of the serial input.
  assign fill_r = rot ? q[WIDTH-1] : sin_r;
  assign fill_l = rot ? q[0]       : sin_l;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign fill_r     = sin_r;
  assign fill_l     = sin_l;
`endif

  assign shl_val = {q[WIDTH-2:0], fill_r};
  assign shr_val = {fill_l, q[WIDTH-1:1]};

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];
  assign busy   = (state == BURST);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      q     <= RESET_VAL;
      cnt   <= '0;
      dir_q <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      cnt   <= cnt_nxt;
      dir_q <= dir_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    cnt_nxt   = cnt;
    dir_nxt   = dir_q;
    case (state)
      IDLE: begin
        if (en) begin
          // start wins over the manual mode and leaves q untouched this cycle
          if (start) begin
            dir_nxt   = dir;
            cnt_nxt   = '0;
            state_nxt = BURST;
          end else begin
            case (mode)
              2'b01:   q_nxt = shl_val;
              2'b10:   q_nxt = shr_val;
              2'b11:   q_nxt = d;
              default: q_nxt = q;
            endcase
          end
        end
      end
      BURST: begin
        if (en) begin
          q_nxt   = dir_q ? shr_val : shl_val;
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        // leaves on the next clock even with en low
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb/tb_shift_reg_ctrl.sv - scoreboard bench for shift_reg_ctrl with a countdown reference model

module tb_shift_reg_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] d;
  logic         sin_l, sin_r, start, dir, rot;
  logic [W-1:0] q;
  logic         sout_l, sout_r, busy, done;

  shift_reg_ctrl #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .start(start), .dir(dir), .rot(rot),
    .q(q), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: a burst is "shifts remaining"; done is a one-cycle flag.
  logic [W-1:0] m_q;
  int           m_left;
  bit           m_done;
  bit           m_dir;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit rot_eff();
`ifdef SHREG_ROTATE_EN
    return rot;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [W-1:0] m_shl(input logic [W-1:0] v);
    logic [W-1:0] fill;
    fill = rot_eff() ? W'((v >> (W - 1)) & 1) : W'(sin_r);
    return W'((v << 1) | fill);
  endfunction

  function automatic logic [W-1:0] m_shr(input logic [W-1:0] v);
    logic [W-1:0] fill;
    fill = rot_eff() ? W'(v & 1) : W'(sin_l);
    return W'((v >> 1) | (fill << (W - 1)));
  endfunction

  task automatic model_reset();
    m_q    = '0;
    m_left = 0;
    m_done = 1'b0;
    m_dir  = 1'b0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      if (en) begin
        m_q = m_dir ? m_shr(m_q) : m_shl(m_q);
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end
    end else if (en) begin
      if (start) begin
        m_dir  = dir;
        m_left = W;
      end else begin
        case (mode)
          2'b01:   m_q = m_shl(m_q);
          2'b10:   m_q = m_shr(m_q);
          2'b11:   m_q = d;
          default: ;
        endcase
      end
    end
  endtask

  // Inputs are set, model predicts the post-edge outputs, then one clock passes.
  task automatic step();
    exp_t e;
    model_edge();
    e.q    = m_q;
    e.busy = (m_left > 0);
    e.done = m_done;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit e_, input logic [1:0] m_, input logic [W-1:0] d_,
                       input bit sl, input bit sr, input bit st, input bit dr, input bit rt);
    en = e_; mode = m_; d = d_; sin_l = sl; sin_r = sr; start = st; dir = dr; rot = rt;
  endtask

  // Monitor: compares the DUT against the oldest pending expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("q",      32'(q),      32'(e.q));
        check("busy",   32'(busy),   32'(e.busy));
        check("done",   32'(done),   32'(e.done));
        check("sout_l", 32'(sout_l), 32'(e.q[W-1]));
        check("sout_r", 32'(sout_r), 32'(e.q[0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] samples;
    int           nbusy, ndone;

    rst_n = 1'b0;
    drive(0, 2'b00, '0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) step();
    check("reset_q", 32'(q), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    rst_n = 1'b1;

    // Load then three left shifts with sin_r=1
    drive(1, 2'b11, 8'hA5, 0, 1, 0, 0, 0); step();
    drive(1, 2'b01, 8'h00, 0, 1, 0, 0, 0);
    repeat (3) step();
    check("shl3_q", 32'(q), 32'h2F);

    // Load, one right shift with sin_l=0, then hold
    drive(1, 2'b11, 8'hA5, 0, 0, 0, 0, 0); step();
    drive(1, 2'b10, 8'h00, 0, 0, 0, 0, 0); step();
    drive(1, 2'b00, 8'hFF, 1, 1, 0, 0, 0);
    repeat (4) step();
    check("hold_q", 32'(q), 32'h52);

    // Right burst on 0xC3, LSB first
    drive(1, 2'b11, 8'hC3, 0, 0, 0, 0, 0); step();
    drive(1, 2'b00, 8'h00, 0, 0, 1, 1, 0);
    nbusy = 0; ndone = 0;
    step();
    nbusy += busy; ndone += done;
    start = 0; dir = 0;
    for (int i = 0; i < W + 1; i++) begin
      if (i < W) samples[i] = sout_r;
      step();
      nbusy += busy; ndone += done;
    end
    check("rburst_sout", 32'(samples), 32'hC3);
    check("rburst_busy_cycles", 32'(nbusy), 32'd8);
    check("rburst_done_pulses", 32'(ndone), 32'd1);
    check("rburst_q", 32'(q), 32'h00);

    // Left burst with a 3-cycle enable gap and start asserted mid-burst
    drive(1, 2'b11, 8'hC3, 0, 0, 0, 0, 0); step();
    drive(1, 2'b00, 8'h00, 0, 0, 1, 0, 0);
    nbusy = 0; ndone = 0;
    step();
    nbusy += busy; ndone += done;
    start = 0;
    for (int i = 0; i < 3; i++) begin
      start = (i == 1); dir = 1;
      step();
      nbusy += busy; ndone += done;
    end
    en = 0; start = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      nbusy += busy; ndone += done;
    end
    en = 1; start = 0; dir = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      nbusy += busy; ndone += done;
    end
    check("lburst_busy_cycles", 32'(nbusy), 32'd11);
    check("lburst_done_pulses", 32'(ndone), 32'd1);
    check("lburst_q", 32'(q), 32'h00);

    // Asynchronous reset in the middle of a burst
    drive(1, 2'b11, 8'hC3, 0, 0, 0, 0, 0); step();
    drive(1, 2'b00, 8'h00, 0, 0, 1, 0, 0); step();
    start = 0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_q", 32'(q), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_done", 32'(done), 32'h0);
    @(negedge clk); #1;
    step();
    rst_n = 1'b1;
    en = 0; step();
    drive(1, 2'b00, 8'h00, 0, 0, 1, 1, 0); step();
    check("restart_busy", 32'(busy), 32'h1);
    start = 0;
    repeat (W + 1) step();

    // Rotate select on a left shift and a right burst
    drive(1, 2'b11, 8'h81, 0, 0, 0, 0, 0); step();
    drive(1, 2'b01, 8'h00, 0, 0, 0, 0, 1); step();
`ifdef SHREG_ROTATE_EN
    check("rot_shl_q", 32'(q), 32'h03);
    drive(1, 2'b11, 8'h81, 0, 0, 0, 0, 0); step();
    drive(1, 2'b00, 8'h00, 0, 0, 1, 1, 1); step();
    start = 0;
    repeat (W + 1) step();
    check("rot_rburst_q", 32'(q), 32'h81);
`else
    check("norot_shl_q", 32'(q), 32'h02);
`endif

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), W'($urandom),
            1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0,
            1'($urandom), 1'($urandom));
      step();
    end

    drive(0, 2'b00, '0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_reg_ctrl.md
Name: shift_reg_ctrl

Overview:
Parametrised universal shift register. It generalises the single-bit D flip-flop to a WIDTH-bit register with four manual modes: hold, shift left, shift right and parallel load. It also has a self-timed burst engine that shifts out a full word serially under a start/busy/done handshake. It sits between parallel datapath registers and serial links, doing PISO/SIPO conversion.

Parameters:
WIDTH, 8, register width in bits; legal range is 2 or more.
RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous, active-low
en  input  1  clock enable; when low, q, state and counter are held
mode  input  2  manual operation: 00 hold, 01 shift left, 10 shift right, 11 parallel load
d  input  WIDTH  parallel load data
sin_l  input  1  serial in; enters the MSB on a right shift
sin_r  input  1  serial in; enters the LSB on a left shift
start  input  1  burst request, sampled in IDLE only
dir  input  1  burst direction, sampled with start: 0 = left (MSB first), 1 = right (LSB first)
rot  input  1  rotate select (see Optional Feature)
q  output  WIDTH  register contents
sout_l  output  1  q[WIDTH-1], combinational from q
sout_r  output  1  q[0], combinational from q
busy  output  1  high while in BURST
done  output  1  high for one cycle after the last burst shift

Behaviour:
- Reset (rst_n low, async, takes effect immediately):
  - q = RESET_VAL; busy = 0; done = 0; shift counter = 0; latched dir = 0; state = IDLE.
  - Reset asserted mid-burst aborts the burst with no done pulse.
- Operations:
  - Shift left: q <= {q[WIDTH-2:0], sin_r}.
  - Shift right: q <= {sin_l, q[WIDTH-1:1]}.
  - Load: q <= d.
- Counter width: clog2(WIDTH)+1 bits; no overflow is possible.
- FSM states are IDLE, BURST and DONE. busy and done decode registered state (busy = state==BURST, done = state==DONE), so they are glitch-free.
- IDLE:
  - en=1 and start=1: latch dir, clear counter, go to BURST. q is unchanged this cycle. start has priority over mode.
  - en=1 and start=0: perform the mode operation.
  - en=0: hold everything.
- BURST:
  - en=1: shift one bit in the latched direction and increment the counter. On the shift where counter==WIDTH-1, go to DONE.
  - en=0: hold q, counter and state; busy stays high.
  - mode, start and dir are ignored.
- DONE:
  - done=1, busy=0. Go to IDLE on the next clock, regardless of en.
  - mode and start are ignored.
- Timing, for a start sampled at edge k with en held high:
  - busy is high from edge k to edge k+WIDTH (WIDTH cycles).
  - Shifts occur at edges k+1 through k+WIDTH.
  - done is high from edge k+WIDTH to edge k+WIDTH+1.
  - The earliest next start is accepted at edge k+WIDTH+2.
- Each en-low cycle during BURST extends busy by one cycle.
- Serial output: sout_l/sout_r show the next bit to leave before each shift. For a left burst, sample sout_l before each shift edge; for a right burst, sample sout_r.

Optional Feature:
Macro SHREG_ROTATE_EN.
- Defined: when rot=1, every shift (manual or burst) feeds back the outgoing bit instead of sin_l/sin_r. Left becomes {q[WIDTH-2:0], q[WIDTH-1]}; right becomes {q[0], q[WIDTH-1:1]}. rot is sampled each shift cycle.
- Undefined: rot is ignored (treated as 0) and no rotate logic is synthesised. The port remains, so benches are shared.

Test Plan:
1. WIDTH=8. Reset, then load d=0xA5; shift left 3 cycles with sin_r=1 -> q=0x4B, 0x97, 0x2F.
2. Load 0xA5; shift right 1 cycle with sin_l=0 -> q=0x52; then mode=00 for 4 cycles -> q stays 0x52.
3. Load 0xC3; start=1, dir=1, sin_l=0 -> sout_r sampled before each shift = 1,1,0,0,0,0,1,1; busy high 8 cycles; done one pulse; final q=0x00.
4. Load 0xC3; start a left burst; drop en for 3 cycles mid-burst -> busy high 11 cycles, q frozen during the gap, done still a single pulse. Assert start during the burst -> no effect.
5. Mid-burst, pull rst_n low between clock edges -> q=0x00, busy=0 immediately without waiting for a clock; no done; after release, a new start is accepted.
6. With SHREG_ROTATE_EN defined: load 0x81, rot=1, shift left -> q=0x03; right burst on 0x81 -> after 8 shifts q=0x81. Without the macro, the same left-shift stimulus with sin_r=0 -> q=0x02.
